gate_exerciser: RTL
===================

GATE_EXERCISER -- requirements
Module: gate_exerciser

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- TRUTH, 4'b1000, expected y for each input vector; bit i is the expected y when {a,b}=i (default is the 2-input AND truth table).
- SETTLE, 1, number of cycles each vector is driven before y is sampled; legal range is 1..15.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state changes on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, request to run one full test pass.
- y, input, 1, output of the gate under test.
- a, output, 1, gate input a; driven as idx[1].
- b, output, 1, gate input b; driven as idx[0].
- busy, output, 1, high while a test pass is running.
- done, output, 1, one-cycle pulse at the end of a pass.
- pass, output, 1, high when the last completed pass had zero mismatches.
- err_count, output, 3, mismatch count for the last pass (0..4).
- fail_vec, output, 4, bit i is set when vector i mismatched.

REQ-003 There SHALL be exactly one clock domain (clk); rst SHALL act asynchronously on all state.

Function
REQ-004 The FSM SHALL have four states:
- IDLE, DRIVE, SAMPLE, DONE.
- Internal state: 2-bit vector index idx and 4-bit settle counter cnt.
REQ-005 In IDLE, a=b=0 and busy=0.
- start=1 at a rising edge SHALL move the FSM to DRIVE with idx=0 and cnt=0.
- The same edge SHALL clear err_count, fail_vec and pass.
REQ-006 While the FSM is in DRIVE or SAMPLE:
- {a,b} SHALL equal idx.
- busy SHALL be 1.
REQ-007 DRIVE SHALL last exactly SETTLE cycles, counted by cnt; on the edge where cnt==SETTLE-1 the FSM SHALL go to SAMPLE.
REQ-008 SAMPLE SHALL last exactly one cycle. On the edge leaving SAMPLE, y SHALL be compared with TRUTH[idx]. On a mismatch:
- err_count SHALL increment.
- fail_vec[idx] SHALL be set.
REQ-009 When leaving SAMPLE:
- If idx<3, idx SHALL increment, cnt SHALL clear, and the FSM SHALL return to DRIVE.
- If idx==3, the FSM SHALL go to DONE.
REQ-010 Pass timing:
- A pass SHALL occupy exactly 4*(SETTLE+1) busy cycles.
- done=1 SHALL occur in the cycle immediately following the last busy cycle.
REQ-011 In DONE:
- done=1, busy=0, a=b=0.
- pass SHALL be updated to (err_count==0), including any mismatch recorded on the final SAMPLE edge.
- The next edge SHALL return the FSM to IDLE unconditionally.
REQ-012 start SHALL be ignored in DRIVE, SAMPLE and DONE; it is accepted only in IDLE. No request SHALL be queued.
REQ-013 err_count, fail_vec and pass SHALL hold their values from DONE until the next accepted start or reset.
REQ-014 err_count SHALL saturate at 4; it cannot exceed this by construction, because there are four vectors per pass.
REQ-015 y SHALL be sampled only on the edge leaving SAMPLE; y changes at any other time SHALL have no effect.

Reset
REQ-016 While rst=1, the FSM SHALL be in IDLE and all of the following SHALL be 0:
- idx, cnt, a, b, busy, done, pass, err_count, fail_vec.
REQ-017 Reset asserted mid-pass SHALL abort the pass immediately and asynchronously, with no done pulse.
REQ-018 After rst deasserts, the first start SHALL run a complete pass from idx=0.

Verification
REQ-019 Bench with an ideal AND gate, TRUTH=4'b1000, SETTLE=1, pulse start:
- {a,b} steps 00,01,10,11, two cycles each.
- busy=1 for 8 cycles.
- done pulses in cycle 9.
- pass=1, err_count=0, fail_vec=0000.
REQ-020 Bench with y tied to 0, TRUTH=4'b1000: err_count=1, fail_vec=1000, pass=0.
REQ-021 Bench with a NAND gate as DUT, TRUTH=4'b1000: err_count=4, fail_vec=1111, pass=0.
REQ-022 SETTLE=3, with start held high through the whole pass:
- busy lasts exactly 16 cycles.
- Exactly one done pulse occurs.
- The FSM returns to IDLE, then a second pass starts on the next edge because start is still high.
- err_count clears at that restart.
REQ-023 Assert rst during DRIVE of vector 2:
- All outputs go to 0 immediately.
- No done pulse.
- A subsequent start yields a full 00..11 sequence with correct results.
REQ-024 A glitch on y during DRIVE, correct y during SAMPLE: no mismatch recorded and pass=1.

Source files
------------

// File: rtl/gate_exerciser.sv
// Drives all four {a,b} vectors into a 2-input gate and checks y against TRUTH.
// Latency: one pass is 4*(SETTLE+1) busy cycles followed by a one-cycle done pulse.
// Backpressure: start is accepted only in IDLE and is never queued.
module gate_exerciser #(
    parameter logic [3:0]  TRUTH  = 4'b1000,
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [1:0] idx, idx_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [2:0] err_nxt;
    logic [3:0] fail_nxt;
    logic       pass_nxt;
    logic       mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            err_count <= err_nxt;
            fail_vec  <= fail_nxt;
            pass      <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        err_nxt   = err_count;
        fail_nxt  = fail_vec;
        pass_nxt  = pass;
        mismatch  = (y != TRUTH[idx]);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    idx_nxt   = 2'd0;
                    cnt_nxt   = 4'd0;
                    err_nxt   = 3'd0;
                    fail_nxt  = 4'd0;
                    pass_nxt  = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt = SAMPLE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            SAMPLE: begin
                // y is only ever looked at here, on the edge leaving SAMPLE
                if (mismatch) begin
                    if (err_count != 3'd4) begin
                        err_nxt = err_count + 3'd1;
                    end
                    fail_nxt[idx] = 1'b1;
                end
                if (idx == 2'd3) begin
                    state_nxt = DONE;
                    pass_nxt  = (err_nxt == 3'd0);
                end else begin
                    state_nxt = DRIVE;
                    idx_nxt   = idx + 2'd1;
                    cnt_nxt   = 4'd0;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // idx keeps its last value after a pass, so gate the pins with busy
    assign busy = (state == DRIVE) || (state == SAMPLE);
    assign done = (state == DONE);
    assign a    = busy & idx[1];
    assign b    = busy & idx[0];

endmodule
